// File: rtl/apb_slave_mem_if.sv
// APB bus between the team's APB master and apb_slave_mem.
// The slverr signal exists only when APB_SLVERR_EN is defined.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    sel;
  logic                    enable;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rdata;
`ifdef APB_SLVERR_EN
  logic                    slverr;

  modport master (
    output sel, enable, write, addr, wdata, strobe,
    input  ready, rdata, slverr
  );
  modport slave (
    input  sel, enable, write, addr, wdata, strobe,
    output ready, rdata, slverr
  );
`else
  modport master (
    output sel, enable, write, addr, wdata, strobe,
    input  ready, rdata
  );
  modport slave (
    input  sel, enable, write, addr, wdata, strobe,
    output ready, rdata
  );
`endif
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with byte strobes and
// WAIT_CYCLES wait states. Optional out-of-range error output: APB_SLVERR_EN.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_slave_mem_if.slave   bus
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int CNT_W   = 4;
  localparam int LANES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];
  logic                    in_range_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    commit_s;

  assign in_range_s = (bus.addr < DEPTH_A);
  assign idx_s      = bus.addr[IDX_W-1:0];

  // A write lands only at the end of a legal, in-range access phase.
  assign commit_s = (state_r == RESP) && bus.sel && bus.enable && bus.write && in_range_s;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: setup phases are only honoured from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.sel && !bus.enable) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s = RESP;
          end else begin
            cnt_nxt_s   = CNT_LOAD;
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!bus.sel) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Memory array with per-byte-lane write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_r[w] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.strobe[b]) begin
          mem_r[idx_s][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response outputs decoded from the state; read data is zero outside a read RESP.
  always_comb begin
    bus.ready = 1'b0;
    bus.rdata = {DATA_WIDTH{1'b0}};
    if (state_r == RESP) begin
      bus.ready = 1'b1;
      if (!bus.write && in_range_s) begin
        bus.rdata = mem_r[idx_s];
      end else begin
        bus.rdata = {DATA_WIDTH{1'b0}};
      end
    end else begin
      bus.ready = 1'b0;
    end
  end

`ifdef APB_SLVERR_EN
  assign bus.slverr = (state_r == RESP) && !in_range_s;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with WAIT_CYCLES 0, 3 and 2
// share one master-side stimulus; each transfer selects one instance via sel.
module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel_v;
  logic        enable;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [2:0]  rdy_s;
  logic [2:0]  err_s;
  logic [31:0] rd_s [3];
  int          rc [3];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  apb_slave_mem #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  apb_slave_mem #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  apb_slave_mem #(.WAIT_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.sel = sel_v[0];  assign bus1.sel = sel_v[1];  assign bus2.sel = sel_v[2];
  assign bus0.enable = enable; assign bus1.enable = enable; assign bus2.enable = enable;
  assign bus0.write = write;   assign bus1.write = write;   assign bus2.write = write;
  assign bus0.addr = addr;     assign bus1.addr = addr;     assign bus2.addr = addr;
  assign bus0.wdata = wdata;   assign bus1.wdata = wdata;   assign bus2.wdata = wdata;
  assign bus0.strobe = strobe; assign bus1.strobe = strobe; assign bus2.strobe = strobe;
  assign rdy_s = {bus2.ready, bus1.ready, bus0.ready};
  assign rd_s[0] = bus0.rdata;
  assign rd_s[1] = bus1.rdata;
  assign rd_s[2] = bus2.rdata;
`ifdef APB_SLVERR_EN
  assign err_s = {bus2.slverr, bus1.slverr, bus0.slverr};
`else
  assign err_s = 3'b000;
`endif

  // Count ready-high cycles per instance.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc[0] <= 0; rc[1] <= 0; rc[2] <= 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rdy_s[k]) rc[k] <= rc[k] + 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One APB transfer; caller is at #1 after a rising edge. Leaves the bus idle at #1
  // after the edge that ends RESP, so a following call is back-to-back.
  task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int waits, output logic err);
    logic done;
    sel_v = 3'b000; sel_v[k] = 1'b1;
    enable = 1'b0; write = wr; addr = a; wdata = d; strobe = s;
    @(posedge clk); #1;
    enable = 1'b1;
    waits = 0; done = 1'b0; rd = 32'h0; err = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rdy_s[k]) begin
        done = 1'b1; rd = rd_s[k]; err = err_s[k];
      end else begin
        waits++;
      end
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL xfer_timeout dut=%0d got_ready=%b expected=1", k, done);
    end
    @(posedge clk); #1;
    sel_v = 3'b000; enable = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int w; logic e;
    total++;
    if (rdy_s !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b expected=000", rdy_s); end
    total++;
    if (rd_s[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h expected=0", rd_s[0]); end
    xfer(0, 1'b0, 32'd3, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h expected=0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd; int w; logic e; int c0;
    c0 = rc[0];
    xfer(0, 1'b1, 32'd3, 32'hDEADBEEF, 4'hF, rd, w, e);
    total++;
    if (w !== 0) begin bad++; $display("FAIL basic_wr_waits got=%0d expected=0", w); end
    xfer(0, 1'b0, 32'd3, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd got=%h expected=deadbeef", rd); end
    idle(2);
    total++;
    if (rc[0] - c0 !== 2) begin bad++; $display("FAIL basic_pulses got=%0d expected=2", rc[0] - c0); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; int w; logic e;
    xfer(0, 1'b1, 32'd5, 32'h11223344, 4'hF, rd, w, e);
    xfer(0, 1'b1, 32'd5, 32'hAABBCCDD, 4'b0101, rd, w, e);
    xfer(0, 1'b0, 32'd5, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_partial got=%h expected=11bb33dd", rd); end
    xfer(0, 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, rd, w, e);
    xfer(0, 1'b0, 32'd5, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_zero got=%h expected=11bb33dd", rd); end
  endtask

  task automatic test_wait();
    logic [31:0] rd; int w; logic e; int c1;
    c1 = rc[1];
    xfer(1, 1'b1, 32'd7, 32'h0BADCAFE, 4'hF, rd, w, e);
    total++;
    if (w !== 3) begin bad++; $display("FAIL wait_wr_waits got=%0d expected=3", w); end
    xfer(1, 1'b0, 32'd7, 32'h0, 4'h0, rd, w, e);
    total++;
    if (w !== 3) begin bad++; $display("FAIL wait_rd_waits got=%0d expected=3", w); end
    total++;
    if (rd !== 32'h0BADCAFE) begin bad++; $display("FAIL wait_rd got=%h expected=0badcafe", rd); end
    idle(2);
    total++;
    if (rc[1] - c1 !== 2) begin bad++; $display("FAIL wait_pulses got=%0d expected=2", rc[1] - c1); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int w; logic e;
    xfer(0, 1'b1, 32'd16, 32'h12345678, 4'hF, rd, w, e);
`ifdef APB_SLVERR_EN
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_slverr got=%b expected=1", e); end
`endif
    xfer(0, 1'b0, 32'd0, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_alias got=%h expected=0", rd); end
`ifdef APB_SLVERR_EN
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL oor_inrange_slverr got=%b expected=0", e); end
`endif
    xfer(0, 1'b0, 32'd16, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd got=%h expected=0", rd); end
`ifdef APB_SLVERR_EN
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_slverr got=%b expected=1", e); end
`endif
    xfer(0, 1'b0, 32'h80000003, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_upper got=%h expected=0", rd); end
    xfer(0, 1'b1, 32'd15, 32'h5A5A0F0F, 4'hF, rd, w, e);
    xfer(0, 1'b0, 32'd15, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h5A5A0F0F) begin bad++; $display("FAIL top_word got=%h expected=5a5a0f0f", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int w; logic e; int c0;
    c0 = rc[0];
    xfer(0, 1'b1, 32'd1, 32'hCAFEF00D, 4'hF, rd, w, e);
    xfer(0, 1'b0, 32'd1, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rd got=%h expected=cafef00d", rd); end
    idle(1);
    total++;
    if (rc[0] - c0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d expected=2", rc[0] - c0); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; int w; logic e; int c2;
    c2 = rc[2];
    sel_v = 3'b100; enable = 1'b0; write = 1'b1; addr = 32'd2; wdata = 32'h55AA55AA; strobe = 4'hF;
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; sel_v = 3'b000; enable = 1'b0; write = 1'b0;
    idle(3);
    total++;
    if (rc[2] !== c2) begin bad++; $display("FAIL abort_ready got=%0d expected=%0d", rc[2], c2); end
    xfer(2, 1'b0, 32'd2, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL abort_nowrite got=%h expected=0", rd); end
    total++;
    if (w !== 2) begin bad++; $display("FAIL abort_waits got=%0d expected=2", w); end
    xfer(2, 1'b1, 32'd4, 32'h0BADF00D, 4'hF, rd, w, e);
    xfer(2, 1'b0, 32'd4, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL u2_rd got=%h expected=0badf00d", rd); end
    // u0 reaches RESP while u2 sits in WAIT, then reset hits both.
    sel_v = 3'b101; enable = 1'b0; write = 1'b1; addr = 32'd9; wdata = 32'h99999999; strobe = 4'hF;
    @(posedge clk); #1; enable = 1'b1;
    #2;
    total++;
    if (rdy_s !== 3'b001) begin bad++; $display("FAIL pre_reset_ready got=%b expected=001", rdy_s); end
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy_s !== 3'b000) begin bad++; $display("FAIL reset_ready_drop got=%b expected=000", rdy_s); end
    @(posedge clk); #1;
    sel_v = 3'b000; enable = 1'b0; write = 1'b0;
    rst_n = 1'b1;
    idle(1);
    xfer(0, 1'b0, 32'd9, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_lost_write got=%h expected=0", rd); end
    xfer(0, 1'b0, 32'd3, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_clear_u0 got=%h expected=0", rd); end
    xfer(1, 1'b0, 32'd7, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_clear_u3 got=%h expected=0", rd); end
    xfer(2, 1'b0, 32'd4, 32'h0, 4'h0, rd, w, e);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_clear_u2 got=%h expected=0", rd); end
  endtask

  initial begin
    rst_n = 1'b0; sel_v = 3'b000; enable = 1'b0; write = 1'b0;
    addr = 32'h0; wdata = 32'h0; strobe = 4'h0;
    #1;
    test_reset_pre();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    idle(1);
    test_reset();
    test_basic();
    test_strobe();
    test_wait();
    idle(1);
    test_out_of_range();
    idle(1);
    test_back_to_back();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic test_reset_pre();
    total++;
    if (rdy_s !== 3'b000) begin bad++; $display("FAIL async_reset_ready got=%b expected=000", rdy_s); end
    total++;
    if (rd_s[1] !== 32'h0) begin bad++; $display("FAIL async_reset_rdata got=%h expected=0", rd_s[1]); end
  endtask

endmodule
